fp_compare_pipe: RTL and testbench
==================================

Name: fp_compare_pipe

Overview:
- Parametrised, fully pipelined FP compare, min/max and classify unit for the FPU in the EX stage.
- Supports single precision (default) or double precision through its exponent and mantissa parameters.
- Accepts one operation per cycle with valid/ready backpressure on both sides, carries a tag through the pipe, and adds FCLASS.
- Results go to the integer regfile (compare/class) or the FP regfile (min/max), selected by o_is_int.

Parameters:
EXP_W, 8, exponent width (11 for double)
MANT_W, 23, stored mantissa width (52 for double)
TAG_W, 5, width of the sideband tag (destination reg) passed through unchanged
FLEN, 1+EXP_W+MANT_W, derived operand/result width; not overridable

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  input operation valid
o_ready  out  1  unit can accept input this cycle
i_operand_a  in  FLEN  fs1
i_operand_b  in  FLEN  fs2 (ignored for FCLASS)
i_op  in  3  0=FEQ 1=FLT 2=FLE 3=FMIN 4=FMAX 5=FCLASS; 6,7 reserved
i_tag  in  TAG_W  sideband, returned with result
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_result  out  FLEN  compare bit / class mask zero-extended, or min/max value
o_is_int  out  1  1 for FEQ/FLT/FLE/FCLASS
o_tag  out  TAG_W  tag of the op in o_result
o_flags  out  5  riscv_pkg::fp_flags_t; only nv is ever set

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous, active-high.
- Input handshake: an input transfers when i_valid && o_ready.
- Output handshake: an output transfers when o_valid && i_ready.
- Pipeline structure: two register stages, S1 and S2. S2 drives the outputs directly.
- Latency: 2 cycles from input transfer to o_valid with no stall. Throughput is 1 op/cycle.
- Advance rule: S2 loads when (!s2_valid || i_ready). S1 loads when (!s1_valid || S2 loads).
- o_ready: o_ready = !s1_valid || S2 loads. This is a combinational path from i_ready and is permitted.
- Stall: while stalled, S1 and S2 contents, o_result, o_flags, o_tag and o_is_int hold stable. No op is dropped or duplicated, and order is preserved.
- S1 contents:
  - registered operands, op and tag;
  - per-operand NaN, sNaN, zero, inf and subnormal flags;
  - magnitude compare of bits [FLEN-2:0]: lt and eq.
- S2 contents:
  - sign-aware lt/eq;
  - result and flags selection per op, registered into the output stage.
- Compare semantics: +0 == -0. Negative < positive. Both negative: larger magnitude is less.
- FEQ: any NaN gives 0; nv = either sNaN.
- FLT/FLE: any NaN gives 0 with nv=1.
- FMIN/FMAX:
  - one NaN: return the other operand;
  - both NaN: return canonical NaN, which is sign 0, exp all-ones, mant MSB=1, rest 0;
  - min(+0,-0) = -0 and max(+0,-0) = +0, in either operand order;
  - nv = either sNaN.
- FCLASS: 10-bit one-hot mask, zero-extended to FLEN.
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0;
  - bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf;
  - bit8 sNaN, bit9 qNaN;
  - nv=0.
- Reserved op: result 0, flags 0, o_is_int 0, o_valid still asserted (op is not dropped).
- Reset values: s1_valid=0, s2_valid=0, o_valid=0, o_result=0, o_flags=0, o_tag=0, o_is_int=0.
  - o_ready reads 1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight ops are discarded. No o_valid is seen after the reset cycle until a new op is accepted.
- Simultaneous events: input accept and output drain in the same cycle with both stages full is legal and is the steady-state full-throughput case.

Test Plan:
1. Default params, back-to-back with i_ready=1:
   - FLT a=0xBF800000, b=0x3F800000 -> result 0x1, o_is_int=1, flags 0, at cycle+2;
   - then FEQ 0x00000000 vs 0x80000000 -> 0x1, on the next cycle.
2. FMIN a=0x00000000, b=0x80000000 -> 0x80000000; FMAX of the same pair -> 0x00000000; o_is_int=0.
3. NaN cases:
   - FMAX a=0x7F800001 (sNaN), b=0x3F800000 -> 0x3F800000, nv=1;
   - FMIN both 0x7FC00000 -> 0x7FC00000, nv=0;
   - FLE a=0x7FC00000 -> 0, nv=1;
   - FEQ a=0x7FC00000 -> 0, nv=0.
4. Backpressure:
   - issue 4 ops with distinct tags 1..4 on consecutive cycles, i_ready=0 for cycles 2-4;
   - required: o_ready drops while both stages are full, outputs stay stable, and tags emerge in order 1,2,3,4 with correct results and none lost.
5. EXP_W=11, MANT_W=52:
   - FCLASS 0xFFF0000000000000 -> 0x001;
   - FCLASS 0x0000000000000001 -> 0x020;
   - FCLASS 0x7FF8000000000000 -> 0x200;
   - FMIN NaN/NaN -> 0x7FF8000000000000.
6. Reset mid-operation: assert i_rst one cycle after accepting two ops -> o_valid=0 and all outputs 0 next cycle, no stale result later, o_ready=1.

Source files
------------

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined FP compare / min-max / classify unit with valid-ready on both sides.
// S1 registers operands plus field decode and magnitude compare; S2 registers the selected result.
module fp_compare_pipe #(
   parameter  int unsigned EXP_W  = 8,
   parameter  int unsigned MANT_W = 23,
   parameter  int unsigned TAG_W  = 5,
   localparam int unsigned FLEN   = 1 + EXP_W + MANT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [FLEN-1:0]  i_operand_a,
   input  logic [FLEN-1:0]  i_operand_b,
   input  logic [2:0]       i_op,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [FLEN-1:0]  o_result,
   output logic             o_is_int,
   output logic [TAG_W-1:0] o_tag,
   output logic [4:0]       o_flags
);

   localparam logic [2:0] OpFeq   = 3'd0;
   localparam logic [2:0] OpFlt   = 3'd1;
   localparam logic [2:0] OpFle   = 3'd2;
   localparam logic [2:0] OpFmin  = 3'd3;
   localparam logic [2:0] OpFmax  = 3'd4;
   localparam logic [2:0] OpFclass = 3'd5;

   localparam logic [FLEN-1:0] CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   typedef struct packed {
      logic [FLEN-1:0]  a;
      logic [FLEN-1:0]  b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic             a_nan;
      logic             a_snan;
      logic             a_zero;
      logic             a_inf;
      logic             a_sub;
      logic             b_nan;
      logic             b_snan;
      logic             b_zero;
      logic             mag_lt;
      logic             mag_eq;
   } s1_t;

   typedef struct packed {
      logic [FLEN-1:0]  result;
      logic [4:0]       flags;
      logic             is_int;
      logic [TAG_W-1:0] tag;
   } s2_t;

   logic s1_valid_d, s1_valid_q;
   logic s2_valid_d, s2_valid_q;
   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;
   logic s1_load, s2_load;

   logic            sign_a, sign_b;
   logic            both_zero, any_nan, any_snan, a_normal;
   logic            lt, eq, a_is_min;
   logic [FLEN-1:0] min_val, max_val;
   logic [9:0]      class_mask;
   logic [FLEN-1:0] res;
   logic            nv;
   logic            is_int;

   function automatic logic exp_max(input logic [FLEN-1:0] x);
      return &x[FLEN-2:MANT_W];
   endfunction

   function automatic logic exp_zero(input logic [FLEN-1:0] x);
      return ~|x[FLEN-2:MANT_W];
   endfunction

   function automatic logic man_zero(input logic [FLEN-1:0] x);
      return ~|x[MANT_W-1:0];
   endfunction

   // o_ready depends combinationally on i_ready through s2_load.
   always_comb begin
      s2_load = !s2_valid_q || i_ready;
      s1_load = !s1_valid_q || s2_load;
   end

   assign o_ready = s1_load;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (s1_load) begin
         s1_valid_d = i_valid;
         if (i_valid) begin
            s1_d.a      = i_operand_a;
            s1_d.b      = i_operand_b;
            s1_d.op     = i_op;
            s1_d.tag    = i_tag;
            s1_d.a_nan  = exp_max(i_operand_a) & ~man_zero(i_operand_a);
            s1_d.a_snan = s1_d.a_nan & ~i_operand_a[MANT_W-1];
            s1_d.a_zero = exp_zero(i_operand_a) & man_zero(i_operand_a);
            s1_d.a_inf  = exp_max(i_operand_a) & man_zero(i_operand_a);
            s1_d.a_sub  = exp_zero(i_operand_a) & ~man_zero(i_operand_a);
            s1_d.b_nan  = exp_max(i_operand_b) & ~man_zero(i_operand_b);
            s1_d.b_snan = s1_d.b_nan & ~i_operand_b[MANT_W-1];
            s1_d.b_zero = exp_zero(i_operand_b) & man_zero(i_operand_b);
            s1_d.mag_lt = i_operand_a[FLEN-2:0] < i_operand_b[FLEN-2:0];
            s1_d.mag_eq = i_operand_a[FLEN-2:0] == i_operand_b[FLEN-2:0];
         end
      end
   end

   // Sign-aware ordering from the S1 magnitude compare.
   always_comb begin
      sign_a    = s1_q.a[FLEN-1];
      sign_b    = s1_q.b[FLEN-1];
      both_zero = s1_q.a_zero & s1_q.b_zero;
      any_nan   = s1_q.a_nan | s1_q.b_nan;
      any_snan  = s1_q.a_snan | s1_q.b_snan;
      a_normal  = ~(s1_q.a_nan | s1_q.a_inf | s1_q.a_zero | s1_q.a_sub);
      if (both_zero) begin
         lt = 1'b0;
         eq = 1'b1;
      end else if (sign_a != sign_b) begin
         lt = sign_a;
         eq = 1'b0;
      end else if (sign_a) begin
         lt = !s1_q.mag_lt && !s1_q.mag_eq;
         eq = s1_q.mag_eq;
      end else begin
         lt = s1_q.mag_lt;
         eq = s1_q.mag_eq;
      end
      // Zeros of opposite sign compare equal, yet min must pick -0 and max +0.
      a_is_min = both_zero ? sign_a : lt;
      min_val  = a_is_min ? s1_q.a : s1_q.b;
      max_val  = a_is_min ? s1_q.b : s1_q.a;
   end

   always_comb begin
      class_mask    = '0;
      class_mask[0] = s1_q.a_inf & sign_a;
      class_mask[1] = a_normal & sign_a;
      class_mask[2] = s1_q.a_sub & sign_a;
      class_mask[3] = s1_q.a_zero & sign_a;
      class_mask[4] = s1_q.a_zero & ~sign_a;
      class_mask[5] = s1_q.a_sub & ~sign_a;
      class_mask[6] = a_normal & ~sign_a;
      class_mask[7] = s1_q.a_inf & ~sign_a;
      class_mask[8] = s1_q.a_snan;
      class_mask[9] = s1_q.a_nan & ~s1_q.a_snan;
   end

   always_comb begin
      res    = '0;
      nv     = 1'b0;
      is_int = 1'b0;
      unique case (s1_q.op)
         OpFeq: begin
            is_int = 1'b1;
            res[0] = eq & ~any_nan;
            nv     = any_snan;
         end
         OpFlt: begin
            is_int = 1'b1;
            res[0] = lt & ~any_nan;
            nv     = any_nan;
         end
         OpFle: begin
            is_int = 1'b1;
            res[0] = (lt | eq) & ~any_nan;
            nv     = any_nan;
         end
         OpFmin, OpFmax: begin
            nv = any_snan;
            if (s1_q.a_nan && s1_q.b_nan) begin
               res = CanonNan;
            end else if (s1_q.a_nan) begin
               res = s1_q.b;
            end else if (s1_q.b_nan) begin
               res = s1_q.a;
            end else begin
               res = (s1_q.op == OpFmin) ? min_val : max_val;
            end
         end
         OpFclass: begin
            is_int = 1'b1;
            res    = FLEN'(class_mask);
         end
         default: begin
            res    = '0;
            is_int = 1'b0;
         end
      endcase
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_d.result = res;
            s2_d.flags  = {nv, 4'b0000};
            s2_d.is_int = is_int;
            s2_d.tag    = s1_q.tag;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

   assign o_valid  = s2_valid_q;
   assign o_result = s2_q.result;
   assign o_flags  = s2_q.flags;
   assign o_is_int = s2_q.is_int;
   assign o_tag    = s2_q.tag;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: single- and double-precision instances, directed vectors,
// hand-written pipeline sequences and random traffic against an ordering-key reference model.
module tb_fp_compare_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, vld, rdy, sel;
   logic [63:0] opa, opb;
   logic [2:0]  opc;
   logic [4:0]  tg;

   logic        s_ready, s_ovalid, s_isint;
   logic [31:0] s_res;
   logic [4:0]  s_tag, s_flags;
   logic        d_ready, d_ovalid, d_isint;
   logic [63:0] d_res;
   logic [4:0]  d_tag, d_flags;

   logic        m_oready, m_ovalid, m_isint;
   logic [63:0] m_res;
   logic [4:0]  m_tag, m_flags;

   assign m_oready = sel ? d_ready  : s_ready;
   assign m_ovalid = sel ? d_ovalid : s_ovalid;
   assign m_isint  = sel ? d_isint  : s_isint;
   assign m_res    = sel ? d_res    : {32'h0, s_res};
   assign m_tag    = sel ? d_tag    : s_tag;
   assign m_flags  = sel ? d_flags  : s_flags;

   fp_compare_pipe #(.EXP_W(8), .MANT_W(23), .TAG_W(5)) u_sp (
      .i_clk(clk), .i_rst(rst), .i_valid(vld & ~sel), .o_ready(s_ready),
      .i_operand_a(opa[31:0]), .i_operand_b(opb[31:0]), .i_op(opc), .i_tag(tg),
      .o_valid(s_ovalid), .i_ready(rdy), .o_result(s_res), .o_is_int(s_isint),
      .o_tag(s_tag), .o_flags(s_flags)
   );

   fp_compare_pipe #(.EXP_W(11), .MANT_W(52), .TAG_W(5)) u_dp (
      .i_clk(clk), .i_rst(rst), .i_valid(vld & sel), .o_ready(d_ready),
      .i_operand_a(opa), .i_operand_b(opb), .i_op(opc), .i_tag(tg),
      .o_valid(d_ovalid), .i_ready(rdy), .o_result(d_res), .o_is_int(d_isint),
      .o_tag(d_tag), .o_flags(d_flags)
   );

   typedef struct {
      logic [63:0] res;
      logic [4:0]  flags;
      logic        is_int;
      logic [4:0]  tag;
   } exp_t;

   typedef struct {
      logic        dbl;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic [4:0]  flags;
      logic        is_int;
   } vec_t;

   int   n_checks = 0;
   int   n_fail = 0;
   int   n_out = 0;
   exp_t sb[$];
   vec_t vecs[21];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // FCLASS bit index of a value, from its fields.
   function automatic int fclass_idx(input logic [63:0] x, input logic dbl);
      int          ew, mw;
      logic [63:0] e, m;
      logic        s;
      ew = dbl ? 11 : 8;
      mw = dbl ? 52 : 23;
      s  = x[ew+mw];
      e  = (x >> mw) & ((64'(1) << ew) - 1);
      m  = x & ((64'(1) << mw) - 1);
      if (e == (64'(1) << ew) - 1) begin
         if (m == 0) return s ? 0 : 7;
         return m[mw-1] ? 9 : 8;
      end
      if (e == 0) begin
         if (m == 0) return s ? 3 : 4;
         return s ? 2 : 5;
      end
      return s ? 1 : 6;
   endfunction

   // Signed integer whose order matches the FP order of non-NaN values (+0 and -0 both map to 0).
   function automatic longint okey(input logic [63:0] x, input logic dbl);
      int          fl;
      logic [63:0] mag;
      fl  = dbl ? 64 : 32;
      mag = x & ((64'(1) << (fl - 1)) - 1);
      return x[fl-1] ? -longint'(mag) : longint'(mag);
   endfunction

   function automatic exp_t model(input logic [2:0] fop, input logic [63:0] x, input logic [63:0] y,
                                  input logic dbl);
      exp_t        r;
      int          ca, cb, ew, mw;
      longint      ka, kb;
      logic [63:0] cnan;
      logic        xneg;
      ew   = dbl ? 11 : 8;
      mw   = dbl ? 52 : 23;
      cnan = (((64'(1) << ew) - 1) << mw) | (64'(1) << (mw - 1));
      ca   = fclass_idx(x, dbl);
      cb   = fclass_idx(y, dbl);
      ka   = okey(x, dbl);
      kb   = okey(y, dbl);
      xneg = x[ew+mw];
      r.res = 0; r.flags = 0; r.is_int = 0; r.tag = 0;
      case (fop)
         3'd0: begin
            r.is_int = 1;
            r.res    = 64'(ca < 8 && cb < 8 && ka == kb);
            if (ca == 8 || cb == 8) r.flags = 5'h10;
         end
         3'd1, 3'd2: begin
            r.is_int = 1;
            if (ca >= 8 || cb >= 8) r.flags = 5'h10;
            else r.res = (fop == 3'd1) ? 64'(ka < kb) : 64'(ka <= kb);
         end
         3'd3, 3'd4: begin
            if (ca == 8 || cb == 8) r.flags = 5'h10;
            if (ca >= 8 && cb >= 8) r.res = cnan;
            else if (ca >= 8) r.res = y;
            else if (cb >= 8) r.res = x;
            else if (ka == kb) r.res = (xneg ^ (fop == 3'd4)) ? x : y;
            else if (fop == 3'd3) r.res = (ka < kb) ? x : y;
            else r.res = (ka < kb) ? y : x;
         end
         3'd5: begin
            r.is_int = 1;
            r.res    = 64'(1) << ca;
         end
         default: ;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] rand_val(input logic dbl);
      int          ew, mw;
      logic [63:0] e, m, s, maxe, r;
      ew   = dbl ? 11 : 8;
      mw   = dbl ? 52 : 23;
      maxe = (64'(1) << ew) - 1;
      s    = 64'($urandom_range(0, 1));
      m    = {$urandom, $urandom} & ((64'(1) << mw) - 1);
      case ($urandom_range(0, 7))
         0: begin e = 0; m = 0; end
         1: begin e = maxe; m = 0; end
         2: begin e = maxe; m = m | (64'(1) << (mw - 1)); end
         3: begin e = maxe; m = (m & ~(64'(1) << (mw - 1))) | 64'(1); end
         4: begin e = 0; m = m | 64'(1); end
         5: begin e = 64'(1) << (ew - 1); m = m & 64'(7); end
         6: e = 64'($urandom_range(1, (1 << ew) - 2));
         default: begin
            r = {$urandom, $urandom};
            return dbl ? r : (r & 64'hFFFF_FFFF);
         end
      endcase
      return (s << (ew + mw)) | (e << mw) | m;
   endfunction

   task automatic gen_op();
      opc = 3'($urandom_range(0, 7));
      opa = rand_val(sel);
      opb = ($urandom_range(0, 5) == 0) ? opa : rand_val(sel);
      if ($urandom_range(0, 7) == 0) opb = opa ^ (64'(1) << (sel ? 63 : 31));
      tg  = 5'($urandom);
   endtask

   // Called #1 after inputs are driven: retire an output transfer, record an input transfer.
   task automatic sb_cycle(output logic acc);
      exp_t e;
      acc = 1'b0;
      if (m_ovalid && rdy) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_out: got o_valid=1 tag %h, required no result pending", m_tag);
         end else begin
            e = sb.pop_front();
            check("sb_result", m_res, e.res);
            check("sb_flags", 64'(m_flags), 64'(e.flags));
            check("sb_is_int", 64'(m_isint), 64'(e.is_int));
            check("sb_tag", 64'(m_tag), 64'(e.tag));
            n_out++;
         end
      end
      if (vld && m_oready) begin
         e     = model(opc, opa, opb, sel);
         e.tag = tg;
         sb.push_back(e);
         acc = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required completion before time limit");
      $fatal(1, "watchdog expired");
   end

   logic [2:0]  bp_op[4];
   logic [63:0] bp_a[4];
   logic [63:0] bp_b[4];
   logic        acc;
   int          idx;

   initial begin
      rst = 1; vld = 0; rdy = 1; sel = 0; opa = 0; opb = 0; opc = 0; tg = 0; acc = 0;

      vecs[0]  = '{0, 3'd1, 64'hBF800000, 64'h3F800000, 64'h1, 5'h00, 1'b1};
      vecs[1]  = '{0, 3'd0, 64'h00000000, 64'h80000000, 64'h1, 5'h00, 1'b1};
      vecs[2]  = '{0, 3'd3, 64'h00000000, 64'h80000000, 64'h80000000, 5'h00, 1'b0};
      vecs[3]  = '{0, 3'd4, 64'h00000000, 64'h80000000, 64'h0, 5'h00, 1'b0};
      vecs[4]  = '{0, 3'd3, 64'h80000000, 64'h00000000, 64'h80000000, 5'h00, 1'b0};
      vecs[5]  = '{0, 3'd4, 64'h80000000, 64'h00000000, 64'h0, 5'h00, 1'b0};
      vecs[6]  = '{0, 3'd4, 64'h7F800001, 64'h3F800000, 64'h3F800000, 5'h10, 1'b0};
      vecs[7]  = '{0, 3'd3, 64'h7FC00000, 64'h7FC00000, 64'h7FC00000, 5'h00, 1'b0};
      vecs[8]  = '{0, 3'd2, 64'h7FC00000, 64'h3F800000, 64'h0, 5'h10, 1'b1};
      vecs[9]  = '{0, 3'd0, 64'h7FC00000, 64'h3F800000, 64'h0, 5'h00, 1'b1};
      vecs[10] = '{0, 3'd1, 64'hC0000000, 64'hBF800000, 64'h1, 5'h00, 1'b1};
      vecs[11] = '{0, 3'd2, 64'h3F800000, 64'h3F800000, 64'h1, 5'h00, 1'b1};
      vecs[12] = '{0, 3'd6, 64'h3F800000, 64'h00000000, 64'h0, 5'h00, 1'b0};
      vecs[13] = '{0, 3'd5, 64'h80000001, 64'h0, 64'h4, 5'h00, 1'b1};
      vecs[14] = '{1, 3'd5, 64'hFFF0000000000000, 64'h0, 64'h001, 5'h00, 1'b1};
      vecs[15] = '{1, 3'd5, 64'h0000000000000001, 64'h0, 64'h020, 5'h00, 1'b1};
      vecs[16] = '{1, 3'd5, 64'h7FF8000000000000, 64'h0, 64'h200, 5'h00, 1'b1};
      vecs[17] = '{1, 3'd3, 64'h7FF8000000000001, 64'h7FF8000000000000, 64'h7FF8000000000000,
                   5'h00, 1'b0};
      vecs[18] = '{0, 3'd0, 64'h7F800001, 64'h3F800000, 64'h0, 5'h10, 1'b1};
      vecs[19] = '{1, 3'd1, 64'h8000000000000000, 64'h0, 64'h0, 5'h00, 1'b1};
      vecs[20] = '{0, 3'd4, 64'hC0000000, 64'hBF800000, 64'hBF800000, 5'h00, 1'b0};

      bp_op[0] = 3'd1; bp_a[0] = 64'hBF800000; bp_b[0] = 64'h3F800000;
      bp_op[1] = 3'd4; bp_a[1] = 64'h00000000; bp_b[1] = 64'h80000000;
      bp_op[2] = 3'd5; bp_a[2] = 64'h7F800000; bp_b[2] = 64'h0;
      bp_op[3] = 3'd0; bp_a[3] = 64'h3F800000; bp_b[3] = 64'h3F800000;

      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      check("rst_s_ready", 64'(s_ready), 1);
      check("rst_s_valid", 64'(s_ovalid), 0);
      check("rst_s_result", 64'(s_res), 0);
      check("rst_s_flags", 64'(s_flags), 0);
      check("rst_s_tag", 64'(s_tag), 0);
      check("rst_s_is_int", 64'(s_isint), 0);
      check("rst_d_ready", 64'(d_ready), 1);
      check("rst_d_valid", 64'(d_ovalid), 0);
      check("rst_d_result", d_res, 0);
      @(negedge clk);

      // Directed vectors, one at a time, with latency check.
      foreach (vecs[i]) begin
         sel = vecs[i].dbl; opc = vecs[i].op; opa = vecs[i].a; opb = vecs[i].b;
         tg = 5'(i); vld = 1; rdy = 1;
         #1 check("vec_accept", 64'(m_oready), 1);
         @(negedge clk);
         vld = 0;
         check("vec_lat1_valid", 64'(m_ovalid), 0);
         @(negedge clk);
         check("vec_lat2_valid", 64'(m_ovalid), 1);
         check("vec_result", m_res, vecs[i].res);
         check("vec_flags", 64'(m_flags), 64'(vecs[i].flags));
         check("vec_is_int", 64'(m_isint), 64'(vecs[i].is_int));
         check("vec_tag", 64'(m_tag), 64'(i));
         @(negedge clk);
      end
      sel = 0;

      // Back-to-back FLT then FEQ.
      vld = 1; rdy = 1; opc = 3'd1; opa = 64'hBF800000; opb = 64'h3F800000; tg = 5'd1;
      @(negedge clk);
      opc = 3'd0; opa = 64'h0; opb = 64'h80000000; tg = 5'd2;
      @(negedge clk);
      vld = 0;
      check("b2b_valid0", 64'(m_ovalid), 1);
      check("b2b_tag0", 64'(m_tag), 1);
      check("b2b_res0", m_res, 1);
      check("b2b_is_int0", 64'(m_isint), 1);
      @(negedge clk);
      check("b2b_valid1", 64'(m_ovalid), 1);
      check("b2b_tag1", 64'(m_tag), 2);
      check("b2b_res1", m_res, 1);
      @(negedge clk);
      check("b2b_idle", 64'(m_ovalid), 0);

      // Backpressure: consumer stalls for cycles 1..3.
      idx = 0; n_out = 0;
      for (int c = 0; c < 12; c++) begin
         rdy = !(c >= 1 && c <= 3);
         if (idx < 4) begin
            vld = 1; opc = bp_op[idx]; opa = bp_a[idx]; opb = bp_b[idx]; tg = 5'(idx + 1);
         end else begin
            vld = 0;
         end
         #1;
         if (c == 2) check("bp_oready_low", 64'(m_oready), 0);
         if (c == 2 || c == 3) begin
            check("bp_hold_valid", 64'(m_ovalid), 1);
            check("bp_hold_tag", 64'(m_tag), 1);
            check("bp_hold_result", m_res, 1);
         end
         sb_cycle(acc);
         if (acc) idx++;
         @(negedge clk);
      end
      check("bp_all_out", 64'(n_out), 4);
      check("bp_sb_empty", 64'(sb.size()), 0);

      // Reset with two ops in flight.
      rdy = 0; vld = 1; opc = 3'd2; opa = 64'h3F800000; opb = 64'h3F800000; tg = 5'd7;
      @(negedge clk);
      opc = 3'd1; opa = 64'hBF800000; opb = 64'h3F800000; tg = 5'd8;
      @(negedge clk);
      vld = 0;
      #1;
      check("pre_rst_valid", 64'(m_ovalid), 1);
      check("pre_rst_tag", 64'(m_tag), 7);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check("midrst_valid", 64'(m_ovalid), 0);
      check("midrst_result", m_res, 0);
      check("midrst_flags", 64'(m_flags), 0);
      check("midrst_tag", 64'(m_tag), 0);
      check("midrst_is_int", 64'(m_isint), 0);
      check("midrst_ready", 64'(m_oready), 1);
      rdy = 1;
      repeat (4) begin
         @(negedge clk);
         #1 check("midrst_no_stale", 64'(m_ovalid), 0);
      end
      @(negedge clk);

      // Random traffic with random backpressure, both precisions.
      for (int p = 0; p < 2; p++) begin
         sel = p[0]; acc = 0; vld = 0;
         for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if (!vld || acc) begin
               if ($urandom_range(0, 4) != 0) begin
                  gen_op();
                  vld = 1;
               end else begin
                  vld = 0;
               end
            end
            #1;
            sb_cycle(acc);
            @(negedge clk);
         end
         vld = 0; rdy = 1;
         repeat (6) begin
            #1;
            sb_cycle(acc);
            @(negedge clk);
         end
         check("rand_sb_empty", 64'(sb.size()), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
